// File: rtl/gf_log_exp_pipe.sv
// gf_log_exp_pipe: NCH-channel GF(2^M) vector<->offset-log converter, 2-stage valid/ready pipe; optional out_zero via GF_LOG_ZERO_FLAG_EN
module gf_log_exp_pipe #(
  parameter int M = 6,
  parameter logic [M:0] PRIM_POLY = 7'h43,
  parameter int NCH = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_mode,
  input  logic [NCH*M-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_mode,
`ifdef GF_LOG_ZERO_FLAG_EN
  output logic [NCH-1:0] out_zero,
`endif
  output logic [NCH*M-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic cfg_err
);
  localparam int Q = 1 << M;
  function automatic logic [M-1:0] nxt(input logic [M-1:0] s);
    return {s[M-2:0], 1'b0} ^ (s[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction
  function automatic logic [Q*M-1:0] gen_exp();
    logic [Q*M-1:0] t = '0;
    logic [M-1:0] s = M'(1);
    for (int k = 0; k < Q - 1; k++) begin
      t[k*M +: M] = s;
      s = nxt(s);
    end
    return t;
  endfunction
  function automatic logic [Q*M-1:0] gen_log();
    logic [Q*M-1:0] t = '0;
    logic [M-1:0] s = M'(1);
    for (int k = 0; k < Q - 1; k++) begin
      t[int'(s)*M +: M] = M'(k);
      s = nxt(s);
    end
    return t;
  endfunction
  // a repeat (including 1 coming back early) or hitting 0 means the poly is not primitive
  function automatic logic gen_err();
    logic [Q-1:0] seen = '0;
    logic e = 1'b0;
    logic [M-1:0] s = M'(1);
    for (int k = 0; k < Q - 1; k++) begin
      if (seen[s] || s == '0) e = 1'b1;
      seen[s] = 1'b1;
      s = nxt(s);
    end
    return e;
  endfunction
  localparam logic [Q*M-1:0] EXP = gen_exp();
  localparam logic [Q*M-1:0] LOG = gen_log();
  localparam logic CFG_ERR = gen_err();
  logic v1, m1, v2, m2, adv1, adv2;
  logic [NCH*M-1:0] d1, d2, lut;
  assign cfg_err = CFG_ERR;
  assign adv2 = !v2 || out_ready;
  assign adv1 = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v2;
  assign out_mode = m2;
  assign out_data = d2;
  always_comb begin
    lut = '0;
    for (int c = 0; c < NCH; c++)
      lut[c*M +: M] = d1[c*M +: M] == '0 ? '0 :
                      m1 ? EXP[int'(d1[c*M +: M] - M'(1))*M +: M] :
                           LOG[int'(d1[c*M +: M])*M +: M] + M'(1);
  end
`ifdef GF_LOG_ZERO_FLAG_EN
  logic [NCH-1:0] zero, z2;
  assign out_zero = z2;
  always_comb begin
    zero = '0;
    for (int c = 0; c < NCH; c++) zero[c] = d1[c*M +: M] == '0;
  end
  always_ff @(posedge clk)
    if (rst) z2 <= '0;
    else if (adv2) z2 <= zero;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      m1 <= 1'b0;
      d1 <= '0;
      v2 <= 1'b0;
      m2 <= 1'b0;
      d2 <= '0;
      xfer_cnt <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        m1 <= in_mode;
        d1 <= in_data;
      end
      if (adv2) begin
        v2 <= v1;
        m2 <= m1;
        d2 <= lut;
      end
      if (v2 && out_ready && xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_gf_log_exp_pipe.sv
// tb_gf_log_exp_pipe: directed self-checking bench for gf_log_exp_pipe
module tb_gf_log_exp_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [11:0] in_data = '0;
  logic in_ready, out_valid, out_mode, cfg_err;
  logic [11:0] out_data;
  logic [15:0] xfer_cnt;
  logic in_ready2, out_valid2, out_mode2, cfg_err2;
  logic [11:0] out_data2;
  logic [2:0] xfer_cnt2;
`ifdef GF_LOG_ZERO_FLAG_EN
  logic [1:0] out_zero, out_zero2;
`endif
  int total = 0, bad = 0, last_cyc = 0;
  logic [11:0] in_d[$], got_d[$];
  logic in_m[$], got_m[$];
  int stall_at = 1000, stall_len = 0;
  always #5 clk = ~clk;
  gf_log_exp_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
`ifdef GF_LOG_ZERO_FLAG_EN
    .out_zero(out_zero),
`endif
    .out_data(out_data), .xfer_cnt(xfer_cnt), .cfg_err(cfg_err));
  gf_log_exp_pipe #(.PRIM_POLY(7'h41), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_mode(out_mode2),
`ifdef GF_LOG_ZERO_FLAG_EN
    .out_zero(out_zero2),
`endif
    .out_data(out_data2), .xfer_cnt(xfer_cnt2), .cfg_err(cfg_err2));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic mode, input logic [11:0] data, input logic [11:0] exp, input string tag);
    in_valid = 1'b1;
    in_mode = mode;
    in_data = data;
    step();
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 1'b0);
    step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_mode"}, out_mode, mode);
  endtask
  task automatic stream();
    int sent = 0, cyc = 0;
    logic held_ok = 1'b0, blocked = 1'b0;
    logic [11:0] held = '0;
    got_d.delete();
    got_m.delete();
    while (got_d.size() < in_d.size() && cyc < 500) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid = sent < in_d.size();
      in_data = in_valid ? in_d[sent] : '0;
      in_mode = in_valid ? in_m[sent] : 1'b0;
      #1;
      if (!in_ready) blocked = 1'b1;
      if (!out_ready && out_valid) begin
        if (held_ok) chk("stall_hold", out_data, held);
        held = out_data;
        held_ok = 1'b1;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_m.push_back(out_mode);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    last_cyc = cyc;
    chk("stream_done", 64'(got_d.size()), 64'(in_d.size()));
    if (stall_len > 0) chk("stall_in_ready_drop", blocked, 1'b1);
  endtask
  initial begin
    logic [63:0] seen;
    logic [11:0] orig[$];
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 12'h0);
    chk("rst_out_mode", out_mode, 1'b0);
    chk("rst_xfer_cnt", xfer_cnt, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("cfg_err_prim", cfg_err, 1'b0);
    chk("cfg_err_nonprim", cfg_err2, 1'b1);
    beat(1'b0, {6'd33, 6'd3}, {6'd63, 6'd7}, "log_33_3");
    beat(1'b1, {6'd63, 6'd7}, {6'd33, 6'd3}, "exp_63_7");
    beat(1'b1, {6'd0, 6'd1}, {6'd0, 6'd1}, "exp_0_1");
    beat(1'b0, {6'd0, 6'd1}, {6'd0, 6'd1}, "log_0_1");
    beat(1'b0, {6'd32, 6'd2}, {6'd6, 6'd2}, "log_32_2");
    step();
    chk("xfer_cnt_5", xfer_cnt, 16'd5);
    // backpressure: 5 beats, out_ready low for 3 cycles mid-stream
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_d = '{{6'd2, 6'd1}, {6'd8, 6'd4}, {6'd32, 6'd16}, {6'd7, 6'd9}, {6'd0, 6'd12}};
    in_m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    stall_at = 2;
    stall_len = 3;
    stream();
    stall_at = 1000;
    stall_len = 0;
    chk("bp_beat0", got_d[0], {6'd2, 6'd1});
    chk("bp_beat1", got_d[1], {6'd4, 6'd3});
    chk("bp_beat2", got_d[2], {6'd6, 6'd5});
    chk("bp_beat3", got_d[3], {6'd3, 6'd12});
    chk("bp_beat3_mode", got_m[3], 1'b1);
    chk("bp_beat4", got_d[4], {6'd0, 6'd9});
    chk("bp_xfer_cnt", xfer_cnt, 16'd5);
    chk("bp_xfer_cnt_w3", xfer_cnt2, 3'd5);
    // full sweep: log then exp round trip
    in_d.delete();
    in_m.delete();
    for (int i = 0; i < 64; i++) begin
      in_d.push_back({6'(63 - i), 6'(i)});
      in_m.push_back(1'b0);
    end
    orig = in_d;
    stream();
    chk("sweep_throughput", 64'(last_cyc), 64'd66);
    chk("sweep_log0", got_d[0][5:0], 6'd0);
    seen = '0;
    for (int i = 1; i < 64; i++) seen[got_d[i][5:0]] = 1'b1;
    chk("sweep_log_unique", seen, 64'hFFFF_FFFF_FFFF_FFFE);
    in_d = got_d;
    in_m.delete();
    for (int i = 0; i < 64; i++) in_m.push_back(1'b1);
    stream();
    for (int i = 0; i < 64; i += 9) chk($sformatf("roundtrip_%0d", i), got_d[i], orig[i]);
    for (int i = 0; i < 64; i++) if (got_d[i] !== orig[i]) chk($sformatf("roundtrip_all_%0d", i), got_d[i], orig[i]);
    chk("roundtrip_mode", got_m[63], 1'b1);
    chk("xfer_cnt_sat_w3", xfer_cnt2, 3'd7);
    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_data = {6'd1, 6'd1};
    step();
    in_data = {6'd2, 6'd2};
    step();
    chk("full_v2", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    in_data = {6'd4, 6'd4};
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_xfer_cnt", xfer_cnt, 16'd0);
    chk("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("flushed_%0d", i), out_valid, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gf_log_exp_pipe.md
Name: gf_log_exp_pipe

Overview:
- Parametrised successor to the two-channel GF(2^6) syndrome-to-log lookup. Converts NCH field elements per beat between vector form and offset-log form ("log+1", 0 reserved for the zero element), in either direction, selected per beat.
- Tables are generated at elaboration from PRIM_POLY. The datapath is a 2-stage valid/ready pipeline with backpressure.
- Sits between the syndrome calculator and the error-locator/Chien stages of the BCH decoder.

Parameters:
- M, 6: field degree. Legal range 3..8.
- PRIM_POLY, 7'h43: primitive polynomial including the x^M term, M+1 bits (default x^6+x+1).
- NCH, 2: number of parallel channels per beat. Legal range 1..8.
- CNT_W, 16: width of the transfer counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept a beat
- in_mode  in  1  0 = log (vector->offset-log), 1 = exp (offset-log->vector)
- in_data  in  NCH*M  channel c occupies bits [c*M +: M]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_mode  out  1  mode travelling with the beat
- out_data  out  NCH*M  converted channels, same packing as in_data
- xfer_cnt  out  CNT_W  number of completed output transfers, saturating
- cfg_err  out  1  static; high if PRIM_POLY is not primitive

Behaviour:
- Table generation: an LFSR starts at alpha^0 = 1 and is multiplied by x modulo PRIM_POLY for k = 0..2^M-2. This gives EXP[k] = alpha^k and LOG[alpha^k] = k. cfg_err = 1 if the value 1 recurs before k = 2^M-1 or any element repeats. Table contents are unspecified when cfg_err = 1.
- Log mode, per channel:
  - input 0 -> output 0.
  - input v != 0 -> output LOG[v] + 1, range 1..2^M-1.
- Exp mode, per channel:
  - input 0 -> output 0.
  - input k in 1..2^M-1 -> output EXP[k-1].
  - Exp of log+1 is the identity. Round trip log->exp returns the original input.
- Arithmetic is M bits, unsigned. The +1 / -1 offset never wraps, because the domain is 1..2^M-1.
- Pipeline registers:
  - Stage 1 registers in_data and in_mode with valid v1.
  - Stage 2 registers the lookup result and mode with valid v2.
  - out_valid = v2; out_data and out_mode come directly from stage 2 registers.
- Advance rules:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1, combinational from out_ready and the valids.
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
- Latency: a beat accepted in cycle t appears with out_valid = 1 in cycle t+2 if there is no stall.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall: while out_valid & !out_ready, out_data and out_mode hold stable. Stage 1 fills, then in_ready drops. No beat is lost or duplicated.
- Simultaneous events: with the pipe full and out_ready = 1, a new input is accepted in the same cycle the output drains.
- Ordering: beats leave strictly in arrival order. Mode may change every beat.
- xfer_cnt: increments by 1 on each output transfer. Holds at 2^CNT_W-1 (saturates).
- Reset values: v1 = v2 = 0; out_valid = 0; out_data = 0; out_mode = 0; xfer_cnt = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded. Beats presented in the reset cycle are not accepted.

Optional Feature:
- Macro: GF_LOG_ZERO_FLAG_EN.
- When defined: adds output port out_zero (NCH bits), registered alongside stage 2.
  - Bit c = 1 when channel c's input was the zero element in log mode, or 0 in exp mode.
  - Resets to 0 and holds with out_data during stalls.
- When undefined: the port and its registers do not exist. All other behaviour is identical.

Test Plan:
- M=6, PRIM_POLY=7'h43, NCH=2, log mode, out_ready=1. in_data channels {ch1=33, ch0=3} -> two cycles later out_data {63, 7}, out_valid=1, cfg_err=0.
- Exp mode, channels {ch1=63, ch0=7} -> out_data {33, 3}. Channels {0, 1} -> out_data {0, 1}.
- Sweep all 64 values per channel: log beat, then exp beat on the result -> round trip returns the inputs. Log of inputs 1..63 yields each value 1..63 exactly once.
- Backpressure: stream 5 beats with out_ready low for 3 cycles mid-stream. in_ready drops once 2 beats are held, output holds stable, all 5 beats emerge in order, xfer_cnt = 5.
- Assert rst for one cycle while v1 = v2 = 1 -> next cycle out_valid = 0, xfer_cnt = 0, in_ready = 1. Flushed beats never appear.
- Non-primitive PRIM_POLY=7'h41 (x^6+1) -> cfg_err = 1. CNT_W=3 with 10 transfers -> xfer_cnt = 7.
